// File: rtl/dp_bram_pipe.sv
// dp_bram_pipe: true dual-port RAM with a configurable read-latency pipeline,
// a hardware clear FSM, a same-address write-collision policy and
// out-of-range address protection.
//
// Port access semantics: there is no backpressure. A port access is accepted
// on any rising edge where the FSM is IDLE and *_en is high. Its result (if
// any) appears on *_dout with a one-cycle *_dout_vld pulse exactly RD_LAT
// cycles later.
module dp_bram_pipe #(
   parameter int W            = 128,
   parameter int DEPTH        = 1024,
   parameter int AW           = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
   parameter int USE_BYTE_EN  = 1,
   parameter int RDW_MODE     = 0,
   parameter int RD_LAT       = 2,
   parameter int CLEAR_ON_RST = 1,
   parameter int COLLIDE_PRI  = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr_req,
   output logic           init_busy,
   output logic           collision,
   input  logic           a_en,
   input  logic           a_we,
   input  logic [AW-1:0]  a_addr,
   input  logic [W-1:0]   a_din,
   input  logic [W/8-1:0] a_be,
   output logic [W-1:0]   a_dout,
   output logic           a_dout_vld,
   input  logic           b_en,
   input  logic           b_we,
   input  logic [AW-1:0]  b_addr,
   input  logic [W-1:0]   b_din,
   input  logic [W/8-1:0] b_be,
   output logic [W-1:0]   b_dout,
   output logic           b_dout_vld
);

   // Reject illegal configurations at elaboration time.
   if (USE_BYTE_EN != 0 && (W % 8) != 0) begin : g_bad_w
      $fatal(1, "dp_bram_pipe: W must be a multiple of 8 when USE_BYTE_EN=1");
   end
   if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw
      $fatal(1, "dp_bram_pipe: RDW_MODE must be 0, 1 or 2");
   end
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $fatal(1, "dp_bram_pipe: RD_LAT must be within 1..4");
   end

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t         state_q;
   logic [AW-1:0]  clr_cnt_q;
   logic           busy_q;
   logic           coll_q;

   logic [W-1:0]   mem [DEPTH];

   // Per-port views, index 0 = port A, index 1 = port B.
   logic           en        [2];
   logic           we        [2];
   logic [AW-1:0]  addr      [2];
   logic [W-1:0]   din       [2];
   logic [W/8-1:0] be        [2];
   logic           in_rng    [2];
   logic [W-1:0]   old_w     [2];
   logic [W-1:0]   new_w     [2];
   logic           acc       [2];
   logic           wr_ok     [2];
   logic           wr_do     [2];
   logic           s1_vld_d  [2];
   logic [W-1:0]   s1_data_d [2];
   logic           same_wr;

   logic [W-1:0]   pd_q [2][RD_LAT];
   logic           pv_q [2][RD_LAT];

   // Byte-lane merge of write data over the stored word.
   function automatic logic [W-1:0] merge_bytes(input logic [W-1:0]   old_v,
                                                input logic [W-1:0]   din_v,
                                                input logic [W/8-1:0] be_v);
      logic [W-1:0] r;
      r = old_v;
      if (USE_BYTE_EN == 0) begin
         r = din_v;
      end else begin
         for (int i = 0; i < W/8; i++) begin
            if (be_v[i]) r[8*i +: 8] = din_v[8*i +: 8];
         end
      end
      return r;
   endfunction

   // Decode both ports: range check, old/merged word, acceptance and winner.
   always_comb begin
      en[0] = a_en;   we[0] = a_we;   addr[0] = a_addr;   din[0] = a_din;   be[0] = a_be;
      en[1] = b_en;   we[1] = b_we;   addr[1] = b_addr;   din[1] = b_din;   be[1] = b_be;
      for (int p = 0; p < 2; p++) begin
         in_rng[p]    = (int'(addr[p]) < DEPTH);
         old_w[p]     = in_rng[p] ? mem[addr[p]] : '0;
         new_w[p]     = merge_bytes(old_w[p], din[p], be[p]);
         acc[p]       = rst_n & (state_q == ST_IDLE) & en[p];
         wr_ok[p]     = acc[p] & we[p] & in_rng[p];
         s1_vld_d[p]  = acc[p] & (!we[p] | (RDW_MODE != 2));
         s1_data_d[p] = (we[p] && RDW_MODE == 0) ? new_w[p] : old_w[p];
      end
      same_wr  = wr_ok[0] & wr_ok[1] & (addr[0] == addr[1]);
      wr_do[0] = wr_ok[0] & !(same_wr & (COLLIDE_PRI == 1));
      wr_do[1] = wr_ok[1] & !(same_wr & (COLLIDE_PRI == 0));
   end

   // Storage array: the clear sweep has priority; otherwise port writes land.
   always_ff @(posedge clk) begin
      if (rst_n && state_q == ST_CLEAR) begin
         mem[clr_cnt_q] <= '0;
      end else begin
         if (wr_do[0]) mem[addr[0]] <= new_w[0];
         if (wr_do[1]) mem[addr[1]] <= new_w[1];
      end
   end

   // Clear FSM with registered busy flag and one-cycle-late collision pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
         clr_cnt_q <= '0;
         busy_q    <= (CLEAR_ON_RST != 0);
         coll_q    <= 1'b0;
      end else begin
         coll_q <= same_wr;
         case (state_q)
            ST_IDLE: begin
               if (clr_req) begin
                  state_q   <= ST_CLEAR;
                  clr_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (clr_cnt_q == LAST_ADDR) begin
                  state_q   <= ST_IDLE;
                  clr_cnt_q <= '0;
                  busy_q    <= 1'b0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Read pipeline: valid shifts every cycle, data only moves with a valid so
   // the last stage holds its value between results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < RD_LAT; s++) begin
               pd_q[p][s] <= '0;
               pv_q[p][s] <= 1'b0;
            end
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            pv_q[p][0] <= s1_vld_d[p];
            if (s1_vld_d[p]) pd_q[p][0] <= s1_data_d[p];
            for (int s = 1; s < RD_LAT; s++) begin
               pv_q[p][s] <= pv_q[p][s-1];
               if (pv_q[p][s-1]) pd_q[p][s] <= pd_q[p][s-1];
            end
         end
      end
   end

   assign init_busy  = busy_q;
   assign collision  = coll_q;
   assign a_dout     = pd_q[0][RD_LAT-1];
   assign a_dout_vld = pv_q[0][RD_LAT-1];
   assign b_dout     = pd_q[1][RD_LAT-1];
   assign b_dout_vld = pv_q[1][RD_LAT-1];

endmodule

// File: tb/tb_dp_bram_pipe.sv
// tb_dp_bram_pipe: directed bench for dp_bram_pipe. Three instances share one
// stimulus stream: u0 (DEPTH=16, byte enables, write-first, port A wins),
// u1 (DEPTH=16, no byte enables, read-first, port B wins) and
// u2 (DEPTH=12, byte enables, no-change, port A wins).
module tb_dp_bram_pipe;

   localparam int W = 128;

   localparam logic [W-1:0] C_AA = {16{8'hAA}};
   localparam logic [W-1:0] C_11 = {16{8'h11}};
   localparam logic [W-1:0] C_FF = {16{8'hFF}};
   localparam logic [W-1:0] C_M  = {{15{8'h11}}, 8'hFF};

   logic          clk;
   logic          rst_n;
   logic          clr_req;
   logic          a_en, a_we, b_en, b_we;
   logic [3:0]    a_addr, b_addr;
   logic [W-1:0]  a_din, b_din;
   logic [15:0]   a_be, b_be;

   logic [W-1:0]  a_dout [3];
   logic [W-1:0]  b_dout [3];
   logic          a_vld  [3];
   logic          b_vld  [3];
   logic          busy   [3];
   logic          coll   [3];

   int n_tests = 0;
   int n_fail  = 0;
   int c0, c1, c2, vs;

   dp_bram_pipe #(.W(W), .DEPTH(16)) u0 (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
      .init_busy(busy[0]), .collision(coll[0]),
      .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_be(a_be),
      .a_dout(a_dout[0]), .a_dout_vld(a_vld[0]),
      .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_be(b_be),
      .b_dout(b_dout[0]), .b_dout_vld(b_vld[0]));

   dp_bram_pipe #(.W(W), .DEPTH(16), .USE_BYTE_EN(0), .RDW_MODE(1), .COLLIDE_PRI(1)) u1 (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
      .init_busy(busy[1]), .collision(coll[1]),
      .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_be(a_be),
      .a_dout(a_dout[1]), .a_dout_vld(a_vld[1]),
      .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_be(b_be),
      .b_dout(b_dout[1]), .b_dout_vld(b_vld[1]));

   dp_bram_pipe #(.W(W), .DEPTH(12), .RDW_MODE(2)) u2 (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
      .init_busy(busy[2]), .collision(coll[2]),
      .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_be(a_be),
      .a_dout(a_dout[2]), .a_dout_vld(a_vld[2]),
      .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_be(b_be),
      .b_dout(b_dout[2]), .b_dout_vld(b_vld[2]));

   // Clock: 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle();
      a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0; clr_req = 1'b0;
      a_be = '1;   b_be = '1;
   endtask

   task automatic wr_a(input logic [3:0] ad, input logic [W-1:0] d, input logic [15:0] e);
      a_en = 1'b1; a_we = 1'b1; a_addr = ad; a_din = d; a_be = e;
   endtask

   task automatic wr_b(input logic [3:0] ad, input logic [W-1:0] d, input logic [15:0] e);
      b_en = 1'b1; b_we = 1'b1; b_addr = ad; b_din = d; b_be = e;
   endtask

   task automatic rd_a(input logic [3:0] ad);
      a_en = 1'b1; a_we = 1'b0; a_addr = ad;
   endtask

   task automatic rd_b(input logic [3:0] ad);
      b_en = 1'b1; b_we = 1'b0; b_addr = ad;
   endtask

   // ev bit i is the expected valid of instance ui.
   task automatic chk_a(input string tag, input logic [2:0] ev,
                        input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
      logic [W-1:0] ed [3];
      ed[0] = d0; ed[1] = d1; ed[2] = d2;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_a_vld_u%0d", tag, i), W'(a_vld[i]), W'(ev[i]));
         check($sformatf("%s_a_dout_u%0d", tag, i), a_dout[i], ed[i]);
      end
   endtask

   task automatic chk_b(input string tag, input logic [2:0] ev,
                        input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
      logic [W-1:0] ed [3];
      ed[0] = d0; ed[1] = d1; ed[2] = d2;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_b_vld_u%0d", tag, i), W'(b_vld[i]), W'(ev[i]));
         check($sformatf("%s_b_dout_u%0d", tag, i), b_dout[i], ed[i]);
      end
   endtask

   task automatic chk_flags(input string tag, input logic eb, input logic ec);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_busy_u%0d", tag, i), W'(busy[i]), W'(eb));
         check($sformatf("%s_coll_u%0d", tag, i), W'(coll[i]), W'(ec));
      end
   endtask

   // Counts busy cycles per instance and any valid pulse over a fixed window.
   // Inputs set by the caller are held for the first cycle only.
   task automatic count_busy(output int n0, output int n1, output int n2, output int nv);
      n0 = 0; n1 = 0; n2 = 0; nv = 0;
      for (int i = 0; i < 40; i++) begin
         smp();
         n0 += int'(busy[0]);
         n1 += int'(busy[1]);
         n2 += int'(busy[2]);
         for (int k = 0; k < 3; k++) nv += int'(a_vld[k]) + int'(b_vld[k]);
         nxt();
         idle();
      end
   endtask

   task automatic chk_counts(input string tag);
      check({tag, "_busy_u0"}, W'(c0), W'(16));
      check({tag, "_busy_u1"}, W'(c1), W'(16));
      check({tag, "_busy_u2"}, W'(c2), W'(12));
      check({tag, "_vld"},     W'(vs), W'(0));
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      smp();
      chk_a("rst", 3'b000, '0, '0, '0);
      chk_b("rst", 3'b000, '0, '0, '0);
      chk_flags("rst", 1'b1, 1'b0);
      nxt();
      rst_n = 1'b1;
      count_busy(c0, c1, c2, vs);
      chk_counts("init");

      // Read of cleared word, latency 2.
      rd_b(4'd5); nxt();
      idle(); smp(); chk_b("t1_early", 3'b000, '0, '0, '0); nxt();
      smp(); chk_b("t1_rd5", 3'b111, '0, '0, '0); nxt();

      // Write then cross-port read; back-to-back reads.
      wr_a(4'd3, C_AA, '1); nxt();
      idle(); rd_b(4'd3); nxt();
      idle(); smp(); chk_a("t2_wr3", 3'b011, C_AA, '0, '0); nxt();
      rd_b(4'd3); smp(); chk_b("t2_rd3", 3'b111, C_AA, C_AA, C_AA); nxt();
      rd_b(4'd4); nxt();
      idle(); smp(); chk_b("t2_bb0", 3'b111, C_AA, C_AA, C_AA); nxt();
      smp(); chk_b("t2_bb1", 3'b111, '0, '0, '0); nxt();
      smp(); chk_b("t2_end", 3'b000, '0, '0, '0); nxt();

      // Byte-enable merge.
      wr_a(4'd9, C_11, '1); nxt();
      wr_a(4'd9, C_FF, 16'h0001); nxt();
      idle(); rd_b(4'd9); smp(); chk_a("t3_wr9a", 3'b011, C_11, '0, '0); nxt();
      idle(); smp(); chk_a("t3_wr9b", 3'b011, C_M, C_11, '0); nxt();
      smp(); chk_b("t3_rd9", 3'b111, C_M, C_FF, C_M); nxt();

      // Same-address dual write.
      wr_a(4'd7, W'(1), '1); wr_b(4'd7, W'(2), '1);
      smp(); chk_flags("t4_pre", 1'b0, 1'b0); nxt();
      idle(); rd_b(4'd7); smp(); chk_flags("t4_pulse", 1'b0, 1'b1); nxt();
      idle(); smp(); chk_flags("t4_after", 1'b0, 1'b0);
      chk_a("t4_awr", 3'b011, W'(1), '0, '0);
      chk_b("t4_bwr", 3'b011, W'(2), '0, C_M); nxt();
      smp(); chk_b("t4_rd7", 3'b111, W'(1), W'(2), W'(1)); nxt();

      // Read-during-write views on port A.
      rd_a(4'd3); nxt();
      wr_a(4'd4, W'(4), '1); nxt();
      wr_a(4'd4, W'(5), '1); smp(); chk_a("t5_rd3", 3'b111, C_AA, C_AA, C_AA); nxt();
      idle(); smp(); chk_a("t5_w4", 3'b011, W'(4), '0, C_AA); nxt();
      smp(); chk_a("t5_w5", 3'b011, W'(5), W'(4), C_AA); nxt();

      // Out-of-range address on the DEPTH=12 instance.
      wr_a(4'd13, W'(32'h77), '1); nxt();
      idle(); rd_b(4'd13); nxt();
      idle(); nxt();
      smp(); chk_b("t6_oor", 3'b111, W'(32'h77), W'(32'h77), '0); nxt();

      // Runtime clear; a read during busy is ignored.
      clr_req = 1'b1; nxt();
      clr_req = 1'b0; rd_b(4'd3);
      count_busy(c0, c1, c2, vs);
      chk_counts("t7_clr");
      rd_b(4'd3); nxt();
      idle(); nxt();
      smp(); chk_b("t7_rd3", 3'b111, '0, '0, '0); nxt();

      // Reset with a read in flight.
      wr_a(4'd3, W'(32'h33), '1); nxt();
      idle(); rd_b(4'd3); nxt();
      idle(); rst_n = 1'b0;
      smp(); chk_a("t8_rst", 3'b000, '0, '0, '0); chk_b("t8_rst", 3'b000, '0, '0, '0);
      chk_flags("t8_rst", 1'b1, 1'b0);
      nxt(); nxt();
      rst_n = 1'b1;
      count_busy(c0, c1, c2, vs);
      chk_counts("t8_rel");

      // Reset part-way through a runtime clear; clear restarts in full.
      clr_req = 1'b1; nxt();
      idle(); repeat (9) nxt();
      rst_n = 1'b0;
      smp(); chk_flags("t9_rst", 1'b1, 1'b0); nxt();
      rst_n = 1'b1;
      count_busy(c0, c1, c2, vs);
      chk_counts("t9_rel");
      rd_b(4'd3); nxt();
      idle(); nxt();
      smp(); chk_b("t9_rd3", 3'b111, '0, '0, '0); nxt();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
